// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares the L2 memory port between refill reads and write-backs.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module l2_mem_arbiter #(
  parameter int ADDR_W        = 28,
  parameter int DATA_W        = 128,
  parameter int MAX_RD_STREAK = 4,
  parameter int STAT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wb_valid,
  input  logic              wb_full,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_pop,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_rd,
  output logic [STAT_W-1:0] stat_wr,
  output logic [STAT_W-1:0] stat_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_BUSY = 2'b01,
    WR_BUSY = 2'b10
  } state_e;

  localparam logic [3:0] MAX_S = 4'(MAX_RD_STREAK);

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_done_q, rd_done_d;
  logic              wb_pop_q, wb_pop_d;

  logic rd_live;
  logic wb_live;
  logic same_addr;
  logic wr_forced;
  logic wr_fill;
  logic is_idle;
  logic grant_rd;
  logic grant_wr;

  // Grant decision; a requester just served is masked for its done/pop cycle.
  // Idle-fill writes also wait that cycle so a refill stream can re-request.
  always_comb begin
    rd_live   = rd_req & ~rd_done_q;
    wb_live   = wb_valid & ~wb_pop_q;
    same_addr = rd_live & wb_live & (wb_addr == rd_addr);
    wr_forced = wb_live & (same_addr | wb_full | (streak_q >= MAX_S));
    wr_fill   = wb_live & ~rd_live & ~rd_done_q;
    is_idle   = (state_q == IDLE);
    grant_wr  = is_idle & (wr_forced | wr_fill);
    grant_rd  = is_idle & rd_live & ~wr_forced;
  end

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    rd_done_d   = 1'b0;
    wb_pop_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d     = WR_BUSY;
          mem_write_d = 1'b1;
          mem_addr_d  = wb_addr;
          mem_wdata_d = wb_data;
        end else if (grant_rd) begin
          state_d    = RD_BUSY;
          mem_read_d = 1'b1;
          mem_addr_d = rd_addr;
        end
      end
      RD_BUSY: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          rd_data_d  = mem_rdata;
          rd_done_d  = 1'b1;
        end
      end
      WR_BUSY: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_write_d = 1'b0;
          wb_pop_d    = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // Consecutive-read counter that bounds write-back starvation.
  always_comb begin
    streak_d = streak_q;
    if (grant_wr) begin
      streak_d = 4'd0;
    end else if (is_idle & ~wb_valid) begin
      streak_d = 4'd0;
    end else if (grant_rd & wb_valid & (streak_q != 4'hF)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // State and output registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_done_q   <= 1'b0;
      wb_pop_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_done_q   <= rd_done_d;
      wb_pop_q    <= wb_pop_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_done   = rd_done_q;
  assign wb_pop    = wb_pop_q;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_rd_q;
  logic [STAT_W-1:0] stat_wr_q;
  logic [STAT_W-1:0] stat_wait_q;
  logic              rd_waiting;

  assign rd_waiting = rd_req & (state_q != RD_BUSY) & ~rd_done_q;

  // Saturating grant and refill-stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_rd_q   <= '0;
      stat_wr_q   <= '0;
      stat_wait_q <= '0;
    end else begin
      if (grant_rd && (stat_rd_q != '1)) begin
        stat_rd_q <= stat_rd_q + STAT_W'(1);
      end
      if (grant_wr && (stat_wr_q != '1)) begin
        stat_wr_q <= stat_wr_q + STAT_W'(1);
      end
      if (rd_waiting && (stat_wait_q != '1)) begin
        stat_wait_q <= stat_wait_q + STAT_W'(1);
      end
    end
  end

  assign stat_rd   = stat_rd_q;
  assign stat_wr   = stat_wr_q;
  assign stat_wait = stat_wait_q;
`endif

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: directed scenarios with a memory model and op scoreboard.
// Stats port checks are active when MEM_ARB_STATS_EN is defined.
module tb_l2_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int SW = 16;

  typedef logic [159:0] v_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wb_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_done;
  logic [DW-1:0] rd_data;
  logic          wb_valid;
  logic          wb_full;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_pop;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef MEM_ARB_STATS_EN
  logic [SW-1:0] stat_rd;
  logic [SW-1:0] stat_wr;
  logic [SW-1:0] stat_wait;
`endif

  l2_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_RD_STREAK(4), .STAT_W(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_full(wb_full),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_pop(wb_pop),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_rd(stat_rd), .stat_wr(stat_wr),
    .stat_wait(stat_wait)
`endif
  );

  always #5 clk = ~clk;

  op_t           exp_ops[$];
  logic [DW-1:0] exp_rd[$];
  logic [AW-1:0] rd_pend[$];
  wb_t           wbq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int lat      = 1;
  int scnt     = 0;
  int cyc      = 0;
  int t_req    = 0;
  int last_lat = 0;
  int n_pop    = 0;
  int wait_cnt = 0;
  int n_chk    = 0;
  int n_err    = 0;
  bit wfull    = 1'b0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {4{4'h0, a}};
  endfunction

  function automatic op_t mkop(input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    op_t o;
    o.wr   = w;
    o.addr = a;
    o.data = d;
    return o;
  endfunction

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_nonempty(input string tag, input int sz);
    n_chk++;
    assert (sz != 0) else begin
      n_err++;
      $error("FAIL %s: observed unexpected event, expected none", tag);
    end
  endtask

  // One clock: requester updates after posedge, memory model at negedge.
  task automatic step();
    op_t got;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_done) begin
      last_lat = cyc - t_req;
      chk_nonempty("rd_done_spurious", exp_rd.size());
      if (exp_rd.size() != 0) chk("rd_data", v_t'(rd_data), v_t'(exp_rd.pop_front()));
      if (rd_pend.size() != 0) void'(rd_pend.pop_front());
      rd_req = 1'b0;
    end else if (rd_pend.size() != 0 && reset) begin
      if (!rd_req) t_req = cyc;
      rd_req  = 1'b1;
      rd_addr = rd_pend[0];
    end
    if (wb_pop) begin
      n_pop++;
      if (wbq.size() != 0) void'(wbq.pop_front());
    end
    wb_valid = (wbq.size() != 0);
    if (wb_valid) begin
      wb_addr = wbq[0].a;
      wb_data = wbq[0].d;
    end
    wb_full = wfull && wb_valid;
    @(negedge clk);
    if (reset && rd_req && !mem_read && !rd_done) wait_cnt++;
    if (mem_read || mem_write) begin
      scnt++;
      if (scnt == lat) begin
        got.wr   = mem_write;
        got.addr = mem_addr;
        got.data = mem_write ? mem_wdata : '0;
        chk("mem_excl", v_t'(mem_read & mem_write), v_t'(0));
        chk_nonempty("mem_op_spurious", exp_ops.size());
        if (exp_ops.size() != 0) chk("mem_op", v_t'(got), v_t'(exp_ops.pop_front()));
        if (mem_write) mem[mem_addr] = mem_wdata;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : pat(mem_addr);
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'b0;
      end
    end else begin
      scnt      = 0;
      mem_ready = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((rd_pend.size() != 0 || wbq.size() != 0 || mem_read || mem_write ||
            rd_done || wb_pop) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, v_t'(rd_pend.size() + wbq.size()), v_t'(0));
    chk({tag, "_ops_left"}, v_t'(exp_ops.size() + exp_rd.size()), v_t'(0));
  endtask

  initial begin
    logic [DW-1:0] dw;
    int n;
    reset     = 1'b0;
    rd_req    = 1'b0;
    rd_addr   = '0;
    wb_valid  = 1'b0;
    wb_full   = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", v_t'({mem_read, mem_write, rd_done, wb_pop}), v_t'(0));
    chk("reset_addr", v_t'(mem_addr), v_t'(0));
    chk("reset_rdata", v_t'(rd_data), v_t'(0));
    @(negedge clk);
    reset = 1'b1;

    // lone read, memory ready in the third strobe cycle
    lat = 3;
    mem[28'h10] = {16{8'hA5}};
    rd_pend.push_back(28'h10);
    exp_ops.push_back(mkop(1'b0, 28'h10, '0));
    exp_rd.push_back({16{8'hA5}});
    drain("lone", 40);
    chk("lone_latency", v_t'(last_lat), v_t'(4));
    chk("lone_no_pop", v_t'(n_pop), v_t'(0));

    // same address: write must reach memory before the refill
    lat = 2;
    dw = {4{32'hDEAD0020}};
    wbq.push_back('{28'h20, dw});
    rd_pend.push_back(28'h20);
    exp_ops.push_back(mkop(1'b1, 28'h20, dw));
    exp_ops.push_back(mkop(1'b0, 28'h20, '0));
    exp_rd.push_back(dw);
    drain("same", 40);
    chk("same_pop", v_t'(n_pop), v_t'(1));

    // starvation: four reads then the pending write
    lat = 1;
    dw = {4{32'hC0DE0040}};
    wbq.push_back('{28'h40, dw});
    for (int i = 0; i < 5; i++) begin
      rd_pend.push_back(28'h100 + AW'(4 * i));
      exp_rd.push_back(pat(28'h100 + AW'(4 * i)));
    end
    for (int i = 0; i < 4; i++)
      exp_ops.push_back(mkop(1'b0, 28'h100 + AW'(4 * i), '0));
    exp_ops.push_back(mkop(1'b1, 28'h40, dw));
    exp_ops.push_back(mkop(1'b0, 28'h110, '0));
    drain("starve", 80);
    chk("starve_streak", v_t'(dut.streak_q), v_t'(0));
    chk("starve_pop", v_t'(n_pop), v_t'(2));

    // full FIFO overrides a waiting refill
    lat = 2;
    wfull = 1'b1;
    dw = {4{32'hF0110080}};
    wbq.push_back('{28'h80, dw});
    rd_pend.push_back(28'h90);
    exp_ops.push_back(mkop(1'b1, 28'h80, dw));
    exp_ops.push_back(mkop(1'b0, 28'h90, '0));
    exp_rd.push_back(pat(28'h90));
    drain("full", 40);
    wfull = 1'b0;

    // reset asserted in the middle of a read
    lat = 6;
    rd_pend.push_back(28'h300);
    n = 0;
    while (!mem_read && n < 10) begin
      step();
      n++;
    end
    chk("rst_strobe_seen", v_t'(mem_read), v_t'(1));
    step();
    #2;
    reset = 1'b0;
    wait_cnt = 0;
    #1;
    chk("rst_mem_read", v_t'(mem_read), v_t'(0));
    chk("rst_done_pop", v_t'({rd_done, wb_pop}), v_t'(0));
    chk("rst_state", v_t'(dut.state_q), v_t'(0));
    rd_pend.delete();
    rd_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    drain("rst", 10);

    // two reads and one write with single-cycle memory
    lat = 1;
    dw = {4{32'h5EED0500}};
    rd_pend.push_back(28'h400);
    rd_pend.push_back(28'h404);
    wbq.push_back('{28'h500, dw});
    exp_ops.push_back(mkop(1'b0, 28'h400, '0));
    exp_ops.push_back(mkop(1'b0, 28'h404, '0));
    exp_ops.push_back(mkop(1'b1, 28'h500, dw));
    exp_rd.push_back(pat(28'h400));
    exp_rd.push_back(pat(28'h404));
    drain("mix", 40);
`ifdef MEM_ARB_STATS_EN
    chk("stat_rd", v_t'(stat_rd), v_t'(2));
    chk("stat_wr", v_t'(stat_wr), v_t'(1));
    chk("stat_wait", v_t'(stat_wait), v_t'(wait_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
